// File: rtl/apb_uart_arbiter_if.sv
// apb_uart_arbiter_if: command side of the shared MasterAPB plus the APB handshake seen on the bus
interface apb_uart_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              m_transfer;
   logic              m_read_write;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic              PENABLE;
   logic              PREADY;
   logic [DATA_W-1:0] PRDATA;
   modport master (output m_transfer, m_read_write, m_addr, m_wdata, input PENABLE, PREADY, PRDATA);
   modport slave (input m_transfer, m_read_write, m_addr, m_wdata, output PENABLE, PREADY, PRDATA);
endinterface

// File: rtl/apb_uart_arbiter.sv
// apb_uart_arbiter: round-robin two-client front end for one MasterAPB, one transfer per grant, with timeout
module apb_uart_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic              PCLK,
   input  logic              PRESTn,
   input  logic              req0,
   input  logic              rw0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              done0,
   output logic              err0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              rw1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              done1,
   output logic              err1,
   output logic [DATA_W-1:0] rdata1,
   apb_uart_arbiter_if.master m
);
   typedef enum logic [1:0] {IDLE, WAIT, RECOVER} state_t;
   state_t state, state_nx;
   logic last_gnt, cur, win, fire, tout, any_req;
   logic [CNT_W-1:0] timer;
   assign any_req = req0 || req1;
   assign win     = (req0 && req1) ? ~last_gnt : req1;
   assign fire    = m.PENABLE && m.PREADY;
   assign tout    = timer == CNT_W'(TIMEOUT - 1);
   // state register
   always_ff @(posedge PCLK or negedge PRESTn) begin
      if (!PRESTn) state <= IDLE;
      else state <= state_nx;
   end
   // next-state: grant on any request, leave WAIT on completion or timeout, one RECOVER cycle
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = any_req ? WAIT : IDLE;
         WAIT:    state_nx = (fire || tout) ? RECOVER : WAIT;
         default: state_nx = IDLE;
      endcase
   end
   // registered outputs: latch winner fields on grant, report completion or abort to the owner only
   always_ff @(posedge PCLK or negedge PRESTn) begin
      if (!PRESTn) begin
         gnt0 <= 1'b0; done0 <= 1'b0; err0 <= 1'b0; rdata0 <= '0;
         gnt1 <= 1'b0; done1 <= 1'b0; err1 <= 1'b0; rdata1 <= '0;
         m.m_transfer <= 1'b0; m.m_read_write <= 1'b0; m.m_addr <= '0; m.m_wdata <= '0;
         last_gnt <= 1'b1; cur <= 1'b0; timer <= '0;
      end else begin
         gnt0 <= 1'b0; gnt1 <= 1'b0; done0 <= 1'b0; done1 <= 1'b0; err0 <= 1'b0; err1 <= 1'b0;
         case (state)
            IDLE: if (any_req) begin
               cur <= win;
               last_gnt <= win;
               timer <= '0;
               m.m_transfer <= 1'b1;
               m.m_read_write <= win ? rw1 : rw0;
               m.m_addr <= win ? addr1 : addr0;
               m.m_wdata <= win ? wdata1 : wdata0;
               gnt0 <= !win;
               gnt1 <= win;
            end
            WAIT: if (fire || tout) begin
               m.m_transfer <= 1'b0;
               if (cur) begin
                  done1 <= 1'b1;
                  err1 <= !fire;
                  if (!fire) rdata1 <= '0;
                  else if (!m.m_read_write) rdata1 <= m.PRDATA;
               end else begin
                  done0 <= 1'b1;
                  err0 <= !fire;
                  if (!fire) rdata0 <= '0;
                  else if (!m.m_read_write) rdata0 <= m.PRDATA;
               end
            end else timer <= timer + 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_apb_uart_arbiter.sv
// tb_apb_uart_arbiter: directed and randomized checks of the arbiter against a round-robin transaction model
module tb_apb_uart_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;
   logic PCLK = 1'b0;
   logic PRESTn = 1'b0;
   logic req0 = 0, rw0 = 0, req1 = 0, rw1 = 0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic gnt0, done0, err0, gnt1, done1, err1;
   logic [DW-1:0] rdata0, rdata1;
   int checks = 0;
   int passed = 0;
   int fails = 0;
   int last_w = 1;
   logic [DW-1:0] exp_rd [2];
   apb_uart_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   apb_uart_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(8)) dut (
      .PCLK(PCLK), .PRESTn(PRESTn),
      .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .done0(done0), .err0(err0), .rdata0(rdata0),
      .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .done1(done1), .err1(err1), .rdata1(rdata1),
      .m(bus)
   );
   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge PCLK);
      @(negedge PCLK);
   endtask

   task automatic model_reset;
      last_w = 1;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"}, {gnt0, gnt1}, 2'b00);
      chk({tag, "_done"}, {done0, done1, err0, err1}, 4'b0000);
      chk({tag, "_rdata0"}, rdata0, 0);
      chk({tag, "_rdata1"}, rdata1, 0);
      chk({tag, "_m_ctl"}, {bus.m_transfer, bus.m_read_write}, 2'b00);
      chk({tag, "_m_addr"}, bus.m_addr, 0);
      chk({tag, "_m_wdata"}, bus.m_wdata, 0);
   endtask

   // One full grant: APB SETUP, lat wait cycles in ACCESS, completion, RECOVER; DUT left in IDLE.
   task automatic do_grant(input int lat, input logic [DW-1:0] prd, output int got);
      int w;
      logic erw;
      logic [AW-1:0] ea;
      logic [DW-1:0] ewd;
      w = (req0 && req1) ? 1 - last_w : (req1 ? 1 : 0);
      erw = w ? rw1 : rw0;
      ea = w ? addr1 : addr0;
      ewd = w ? wdata1 : wdata0;
      tick;
      got = gnt1 ? 1 : 0;
      chk("gnt0", gnt0, w == 0);
      chk("gnt1", gnt1, w == 1);
      chk("m_transfer_grant", bus.m_transfer, 1);
      chk("m_addr", bus.m_addr, ea);
      chk("m_read_write", bus.m_read_write, erw);
      chk("m_wdata", bus.m_wdata, ewd);
      last_w = w;
      if (w == 1) begin addr1 = $urandom; wdata1 = $urandom; rw1 = 1'($urandom); end
      else begin addr0 = $urandom; wdata0 = $urandom; rw0 = 1'($urandom); end
      tick;
      chk("setup_hold", {bus.m_transfer, bus.m_addr}, {1'b1, ea});
      bus.PENABLE = 1'b1;
      repeat (lat) begin
         tick;
         chk("wait_no_done", {done0, done1, bus.m_transfer}, 3'b001);
      end
      bus.PREADY = 1'b1;
      bus.PRDATA = prd;
      tick;
      bus.PENABLE = 1'b0;
      bus.PREADY = 1'b0;
      bus.PRDATA = $urandom;
      if (!erw) exp_rd[w] = prd;
      chk("done_w", w ? done1 : done0, 1);
      chk("err_w", w ? err1 : err0, 0);
      chk("done_other", w ? done0 : done1, 0);
      chk("rdata0", rdata0, exp_rd[0]);
      chk("rdata1", rdata1, exp_rd[1]);
      chk("m_transfer_done", bus.m_transfer, 0);
      tick;
      chk("recover", {bus.m_transfer, gnt0, gnt1, done0, done1}, 5'b00000);
      chk("recover_addr_hold", bus.m_addr, ea);
   endtask

   initial begin
      int got;
      bus.PENABLE = 1'b0;
      bus.PREADY = 1'b0;
      bus.PRDATA = '0;
      model_reset();
      repeat (2) tick;
      chk_all_zero("reset");
      PRESTn = 1'b1;
      tick;
      // single write to 2004
      req0 = 1; rw0 = 1; addr0 = 2004; wdata0 = 0;
      do_grant(2, 32'h1234_5678, got);
      req0 = 0;
      // simultaneous requests after reset: requester 0 first, then the read for requester 1
      PRESTn = 1'b0;
      tick;
      PRESTn = 1'b1;
      model_reset();
      req0 = 1; rw0 = 1; addr0 = 2000; wdata0 = 32'h18;
      req1 = 1; rw1 = 0; addr1 = 2008;
      do_grant(1, 32'h5555_5555, got);
      chk("tie_first", got, 0);
      req0 = 0;
      do_grant(0, 32'h0000_00CB, got);
      chk("tie_second", got, 1);
      chk("rdata1_cb", rdata1, 32'hCB);
      chk("rdata0_untouched", rdata0, 0);
      // both held: alternation
      req0 = 1; req1 = 1;
      for (int i = 0; i < 6; i++) begin
         do_grant($urandom_range(0, 3), $urandom, got);
         chk("rr_order", got, i % 2);
      end
      req0 = 0; req1 = 0;
      // read then write from the same requester keeps read data
      req1 = 1; rw1 = 0; addr1 = 2008;
      do_grant(1, 32'hBF5E_9D02, got);
      chk("rd_bf5e", rdata1, 32'hBF5E_9D02);
      rw1 = 1; addr1 = 2004; wdata1 = 32'h41;
      do_grant(2, 32'hDEAD_BEEF, got);
      chk("rd_kept_after_write", rdata1, 32'hBF5E_9D02);
      // timeout on a read with PREADY stuck low
      rw1 = 0; addr1 = 2008;
      tick;
      chk("to_gnt1", gnt1, 1);
      last_w = 1;
      req1 = 0;
      for (int i = 1; i < TO; i++) begin
         if (i == 2) bus.PENABLE = 1'b1;
         tick;
         chk("to_no_done", {done0, done1, bus.m_transfer}, 3'b001);
      end
      tick;
      exp_rd[1] = '0;
      chk("to_done1", {done1, err1}, 2'b11);
      chk("to_rdata1", rdata1, 0);
      chk("to_m_transfer", bus.m_transfer, 0);
      chk("to_done0", done0, 0);
      bus.PENABLE = 1'b0;
      tick;
      chk("to_recover", {bus.m_transfer, done1, err1}, 3'b000);
      // asynchronous reset in the middle of a write
      req0 = 1; rw0 = 1; addr0 = 2004; wdata0 = 32'h77;
      tick;
      chk("rst_gnt0", gnt0, 1);
      tick;
      bus.PENABLE = 1'b1;
      tick;
      PRESTn = 1'b0;
      #1;
      chk_all_zero("async_rst");
      bus.PREADY = 1'b1;
      @(negedge PCLK);
      chk("rst_no_done0", {done0, err0}, 2'b00);
      PRESTn = 1'b1;
      bus.PENABLE = 1'b0;
      bus.PREADY = 1'b0;
      model_reset();
      do_grant(1, 32'h0, got);
      chk("rst_regrant", got, 0);
      req0 = 0;
      // randomized traffic
      for (int i = 0; i < 24; i++) begin
         req0 = 1'($urandom); req1 = 1'($urandom);
         if (!req0 && !req1) req0 = 1;
         rw0 = 1'($urandom); rw1 = 1'($urandom);
         addr0 = $urandom; addr1 = $urandom;
         wdata0 = $urandom; wdata1 = $urandom;
         do_grant($urandom_range(0, 4), $urandom, got);
      end
      req0 = 0; req1 = 0;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
